// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundle of every non-clock signal between the instruction-fetch
//               requester (I), the data requester (D), the shared mem_system
//               and mem_arbiter.
//               I side : i_addr, i_rd -> i_data, i_done, i_stall, i_err
//               D side : d_addr, d_wdata, d_rd, d_wr -> d_data, d_done,
//                        d_stall, d_err
//               Memory : mem_addr, mem_wdata, mem_rd, mem_wr ->
//                        mem_rdata, mem_done, mem_err, mem_hit
//               Status : hit_cnt
//               modport master : the arbiter's view
//               modport slave  : the view of the surrounding requesters and
//                                memory
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] i_addr;
    logic              i_rd;
    logic [DATA_W-1:0] i_data;
    logic              i_done;
    logic              i_stall;
    logic              i_err;

    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rd;
    logic              d_wr;
    logic [DATA_W-1:0] d_data;
    logic              d_done;
    logic              d_stall;
    logic              d_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_err;
    logic              mem_hit;

    logic [15:0]       hit_cnt;

    modport master (
        input  i_addr, i_rd, d_addr, d_wdata, d_rd, d_wr,
               mem_rdata, mem_done, mem_err, mem_hit,
        output i_data, i_done, i_stall, i_err,
               d_data, d_done, d_stall, d_err,
               mem_addr, mem_wdata, mem_rd, mem_wr, hit_cnt
    );

    modport slave (
        output i_addr, i_rd, d_addr, d_wdata, d_rd, d_wr,
               mem_rdata, mem_done, mem_err, mem_hit,
        input  i_data, i_done, i_stall, i_err,
               d_data, d_done, d_stall, d_err,
               mem_addr, mem_wdata, mem_rd, mem_wr, hit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one mem_system between the read-only instruction port
//               (I) and the read/write data port (D). The winning request is
//               latched in IDLE and replayed unchanged to memory until
//               mem_done; DataOut/Done/err are then routed to the winner in
//               the same cycle.
//               Ports : clk, rst (synchronous, active high)
//                       bus (mem_arbiter_if.master) - I, D and memory sides
//                       plus the saturating hit_cnt
//               Parameters : ADDR_W, DATA_W, STARVE_MAX (1..15)
//               Build option : MEM_ARB_RR_EN - round-robin arbitration
//                              instead of fixed D priority with
//                              anti-starvation for I.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_rd,    w_rd_nxt;
    logic              r_wr,    w_wr_nxt;
    logic [3:0]        r_starve, w_starve_nxt;
    logic [15:0]       r_hit_cnt;

    logic w_i_req;
    logic w_d_illegal;
    logic w_d_req;
    logic w_pick_i;
    logic w_pick_d;
    logic w_idle;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_hit_inc;

    assign w_idle      = (r_state == IDLE);
    assign w_gnt_i     = (r_state == GNT_I);
    assign w_gnt_d     = (r_state == GNT_D);

    assign w_i_req     = bus.i_rd;
    // A simultaneous load+store is not a valid D request; it is refused
    // outright so that I can still use the cycle.
    assign w_d_illegal = bus.d_rd & bus.d_wr;
    assign w_d_req     = (bus.d_rd | bus.d_wr) & ~w_d_illegal;

`ifdef MEM_ARB_RR_EN
    logic r_rr_last_d, w_rr_last_d_nxt;

    // On a tie the port that did not win last time gets the grant.
    assign w_pick_i = w_i_req & (~w_d_req | r_rr_last_d);
`else
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    // D wins ties unless I has already been passed over STARVE_MAX times.
    assign w_pick_i = w_i_req & (~w_d_req | (r_starve == c_starve_max));
`endif
    assign w_pick_d = w_d_req & ~w_pick_i;

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_rd_nxt     = r_rd;
        w_wr_nxt     = r_wr;
        w_starve_nxt = r_starve;
`ifdef MEM_ARB_RR_EN
        w_rr_last_d_nxt = r_rr_last_d;
`endif
        case (r_state)
            IDLE: begin
                if (w_pick_i) begin
                    w_state_nxt = GNT_I;
                    w_addr_nxt  = bus.i_addr;
                    w_rd_nxt    = 1'b1;
                    w_wr_nxt    = 1'b0;
`ifdef MEM_ARB_RR_EN
                    w_rr_last_d_nxt = 1'b0;
`endif
                end else if (w_pick_d) begin
                    w_state_nxt = GNT_D;
                    w_addr_nxt  = bus.d_addr;
                    w_wdata_nxt = bus.d_wdata;
                    w_rd_nxt    = bus.d_rd;
                    w_wr_nxt    = bus.d_wr;
`ifdef MEM_ARB_RR_EN
                    w_rr_last_d_nxt = 1'b1;
`endif
                end
            end
            GNT_I, GNT_D: begin
                if (bus.mem_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

`ifdef MEM_ARB_RR_EN
        w_starve_nxt = 4'd0;
`else
        if (!bus.i_rd) begin
            w_starve_nxt = 4'd0;
        end else if (w_idle && w_pick_d) begin
            w_starve_nxt = r_starve + 4'd1;
        end else if (w_idle && w_pick_i) begin
            w_starve_nxt = 4'd0;
        end
`endif
    end

    assign w_hit_inc = ~w_idle & bus.mem_done & bus.mem_hit & (r_hit_cnt != 16'hFFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_starve  <= 4'd0;
            r_hit_cnt <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rd      <= w_rd_nxt;
            r_wr      <= w_wr_nxt;
            r_starve  <= w_starve_nxt;
            if (w_hit_inc) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last_d <= 1'b1;
        end else begin
            r_rr_last_d <= w_rr_last_d_nxt;
        end
    end
`endif

    // Memory side is driven only from the latched request.
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_rd    = (w_gnt_i | w_gnt_d) & r_rd;
    assign bus.mem_wr    = (w_gnt_i | w_gnt_d) & r_wr;

    // Completion is routed combinationally to whichever port owns memory.
    assign bus.i_done  = w_gnt_i & bus.mem_done;
    assign bus.i_data  = bus.i_done ? bus.mem_rdata : '0;
    assign bus.i_err   = bus.i_done & bus.mem_err;
    assign bus.i_stall = bus.i_rd & ~bus.i_done;

    assign bus.d_done  = w_gnt_d & bus.mem_done;
    assign bus.d_data  = bus.d_done ? bus.mem_rdata : '0;
    assign bus.d_err   = (bus.d_done & bus.mem_err) | (w_idle & w_d_illegal);
    assign bus.d_stall = (bus.d_rd | bus.d_wr) & ~bus.d_done;

    assign bus.hit_cnt = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level
//               model (owner of memory, latched request, grant rules) predicts
//               every output on every cycle; directed sequences with literal
//               expectations pin the model, followed by randomized requesters
//               and memory responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model and per-cycle compare
    // owner: 0 = memory free, 1 = I owns it, 2 = D owns it
    // ------------------------------------------------------------------
    int          m_owner  = 0;
    logic [15:0] m_addr   = 16'h0;
    logic [15:0] m_wdata  = 16'h0;
    bit          m_rd     = 1'b0;
    bit          m_wr     = 1'b0;
    int          m_starve = 0;
    bit          m_rr_d   = 1'b1;
    int          m_hits   = 0;

    initial begin : compare
        logic e_mem_rd, e_mem_wr, e_i_done, e_d_done, e_i_err, e_d_err;
        logic [15:0] e_i_data, e_d_data;
        bit i_req, d_req;
        int win;
        forever begin
            @(negedge clk);
            e_mem_rd = 1'b0; e_mem_wr = 1'b0;
            e_i_done = 1'b0; e_d_done = 1'b0;
            e_i_err  = 1'b0; e_d_err  = 1'b0;
            e_i_data = 16'h0; e_d_data = 16'h0;
            if (m_owner == 0) begin
                e_d_err = bus.d_rd & bus.d_wr;
            end else if (m_owner == 1) begin
                e_mem_rd = 1'b1;
                e_i_done = bus.mem_done;
                e_i_data = bus.mem_done ? bus.mem_rdata : 16'h0;
                e_i_err  = bus.mem_done & bus.mem_err;
            end else begin
                e_mem_rd = m_rd;
                e_mem_wr = m_wr;
                e_d_done = bus.mem_done;
                e_d_data = bus.mem_done ? bus.mem_rdata : 16'h0;
                e_d_err  = bus.mem_done & bus.mem_err;
            end

            if (chk_en) begin
                chk1 ("mem_rd",  bus.mem_rd,  e_mem_rd);
                chk1 ("mem_wr",  bus.mem_wr,  e_mem_wr);
                chk1 ("i_done",  bus.i_done,  e_i_done);
                chk1 ("d_done",  bus.d_done,  e_d_done);
                chk1 ("i_err",   bus.i_err,   e_i_err);
                chk1 ("d_err",   bus.d_err,   e_d_err);
                chk16("i_data",  bus.i_data,  e_i_data);
                chk16("d_data",  bus.d_data,  e_d_data);
                chk1 ("i_stall", bus.i_stall, bus.i_rd & ~e_i_done);
                chk1 ("d_stall", bus.d_stall, (bus.d_rd | bus.d_wr) & ~e_d_done);
                chk16("hit_cnt", bus.hit_cnt, 16'(m_hits));
                if (m_owner != 0)
                    chk16("mem_addr", bus.mem_addr, m_addr);
                if (m_owner == 2 && m_wr)
                    chk16("mem_wdata", bus.mem_wdata, m_wdata);
            end

            if (rst) begin
                m_owner = 0; m_starve = 0; m_rr_d = 1'b1; m_hits = 0;
                m_rd = 1'b0; m_wr = 1'b0;
            end else begin
                win = 0;
                i_req = bus.i_rd;
                d_req = (bus.d_rd | bus.d_wr) && !(bus.d_rd && bus.d_wr);
                if (m_owner != 0) begin
                    if (bus.mem_done) begin
                        if (bus.mem_hit && m_hits < 65535) m_hits++;
                        m_owner = 0;
                    end
                end else begin
                    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                        win = m_rr_d ? 1 : 2;
`else
                        win = (m_starve == STARVE_MAX) ? 1 : 2;
`endif
                    end else if (i_req) begin
                        win = 1;
                    end else if (d_req) begin
                        win = 2;
                    end
                    if (win == 1) begin
                        m_owner = 1; m_addr = bus.i_addr; m_rd = 1'b1; m_wr = 1'b0; m_rr_d = 1'b0;
                    end else if (win == 2) begin
                        m_owner = 2; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
                        m_rd = bus.d_rd; m_wr = bus.d_wr; m_rr_d = 1'b1;
                    end
                end
`ifdef MEM_ARB_RR_EN
                m_starve = 0;
`else
                if (!bus.i_rd)     m_starve = 0;
                else if (win == 2) m_starve = m_starve + 1;
                else if (win == 1) m_starve = 0;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_addr = 16'h0; bus.i_rd = 1'b0;
        bus.d_addr = 16'h0; bus.d_wdata = 16'h0; bus.d_rd = 1'b0; bus.d_wr = 1'b0;
        bus.mem_rdata = 16'h0; bus.mem_done = 1'b0; bus.mem_err = 1'b0; bus.mem_hit = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin : stim
        bit   i_act, d_act, d_op, ill, i_seen, d_seen;
        int   n_gnt;
        logic [9:0] got_order;
        logic [9:0] exp_order;

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk16("rst_hit_cnt", bus.hit_cnt, 16'h0);
        chk1 ("rst_mem_rd",  bus.mem_rd,  1'b0);
        chk1 ("rst_mem_wr",  bus.mem_wr,  1'b0);
        chk1 ("rst_i_done",  bus.i_done,  1'b0);
        chk1 ("rst_d_done",  bus.d_done,  1'b0);
        step();

        // I-only read of 0x0040, memory answers in the first grant cycle
        bus.i_rd = 1'b1; bus.i_addr = 16'h0040;
        @(negedge clk);
        chk1("t1_req_mem_rd", bus.mem_rd, 1'b0);
        chk1("t1_req_stall",  bus.i_stall, 1'b1);
        step();
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h5A5A; bus.mem_hit = 1'b1;
        @(negedge clk);
        chk1 ("t1_gnt_mem_rd", bus.mem_rd,   1'b1);
        chk16("t1_gnt_addr",   bus.mem_addr, 16'h0040);
        chk1 ("t1_i_done",     bus.i_done,   1'b1);
        chk16("t1_i_data",     bus.i_data,   16'h5A5A);
        chk1 ("t1_i_stall",    bus.i_stall,  1'b0);
        step();
        bus.i_rd = 1'b0; bus.mem_done = 1'b0; bus.mem_hit = 1'b0;
        @(negedge clk);
        chk1 ("t1_after_mem_rd", bus.mem_rd,  1'b0);
        chk1 ("t1_after_stall",  bus.i_stall, 1'b0);
        chk16("t1_hit_cnt",      bus.hit_cnt, 16'h0001);

        // D write 0x1234 <- 0xBEEF; requester changes its address mid-grant
        do_reset();
        bus.d_wr = 1'b1; bus.d_addr = 16'h1234; bus.d_wdata = 16'hBEEF;
        @(negedge clk);
        chk1("t2_req_mem_wr", bus.mem_wr, 1'b0);
        step();
        bus.d_addr = 16'h0000; bus.d_wdata = 16'h0000;
        @(negedge clk);
        chk16("t2_addr_hold",  bus.mem_addr,  16'h1234);
        chk16("t2_wdata_hold", bus.mem_wdata, 16'hBEEF);
        chk1 ("t2_mem_wr",     bus.mem_wr,    1'b1);
        step();
        @(negedge clk);
        chk16("t2_addr_hold2", bus.mem_addr, 16'h1234);
        chk1 ("t2_mem_wr2",    bus.mem_wr,   1'b1);
        step();
        bus.mem_done = 1'b1; bus.mem_hit = 1'b1;
        @(negedge clk);
        chk1("t2_d_done",  bus.d_done,  1'b1);
        chk1("t2_d_stall", bus.d_stall, 1'b0);
        step();
        bus.d_wr = 1'b0; bus.mem_done = 1'b0; bus.mem_hit = 1'b0;
        @(negedge clk);
        chk1("t2_after_mem_wr", bus.mem_wr, 1'b0);

        // Illegal D request in IDLE while I requests; then mem_err on I
        do_reset();
        bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.i_rd = 1'b1; bus.i_addr = 16'h0100;
        @(negedge clk);
        chk1("t3_d_err_ill", bus.d_err,  1'b1);
        chk1("t3_no_mem_rd", bus.mem_rd, 1'b0);
        chk1("t3_no_mem_wr", bus.mem_wr, 1'b0);
        step();
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.mem_done = 1'b1; bus.mem_err = 1'b1;
        @(negedge clk);
        chk16("t3_i_addr",  bus.mem_addr, 16'h0100);
        chk1 ("t3_i_err",   bus.i_err,    1'b1);
        chk1 ("t3_d_err",   bus.d_err,    1'b0);
        chk1 ("t3_d_done",  bus.d_done,   1'b0);
        step();
        idle_inputs();

        // Three hits, then reset while a D write waits in its grant
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.i_rd = 1'b1; bus.i_addr = 16'(k);
            @(negedge clk);
            step();
            bus.mem_done = 1'b1; bus.mem_hit = 1'b1;
            @(negedge clk);
            step();
            bus.i_rd = 1'b0; bus.mem_done = 1'b0; bus.mem_hit = 1'b0;
            @(negedge clk);
            step();
        end
        @(negedge clk);
        chk16("t4_hit_cnt3", bus.hit_cnt, 16'h0003);
        step();
        bus.d_wr = 1'b1; bus.d_addr = 16'h2222; bus.d_wdata = 16'h1111;
        @(negedge clk);
        step();
        @(negedge clk);
        chk1("t4_gnt_d_mem_wr", bus.mem_wr, 1'b1);
        step();
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0; bus.d_wr = 1'b0;
        @(negedge clk);
        chk1 ("t4_rst_mem_wr", bus.mem_wr,  1'b0);
        chk16("t4_rst_hits",   bus.hit_cnt, 16'h0000);

        // Both ports requesting continuously: grant order
        do_reset();
        bus.i_rd = 1'b1; bus.i_addr = 16'h00A0;
        bus.d_wr = 1'b1; bus.d_addr = 16'h00D0; bus.d_wdata = 16'h0001;
        bus.mem_done = 1'b1;
        n_gnt = 0;
        got_order = '0;
`ifdef MEM_ARB_RR_EN
        exp_order = 10'b1010101010;
`else
        exp_order = 10'b0111101111;
`endif
        for (int c = 0; c < 60 && n_gnt < 10; c++) begin
            @(negedge clk);
            if (bus.mem_rd || bus.mem_wr) begin
                got_order[n_gnt] = bus.mem_wr;
                n_gnt++;
            end
            step();
        end
        chk16("grant_count", 16'(n_gnt), 16'd10);
        for (int k = 0; k < 10; k++)
            chk1("grant_order", got_order[k], exp_order[k]);
        idle_inputs();

        // Randomized traffic
        do_reset();
        i_act = 1'b0; d_act = 1'b0; d_op = 1'b0; i_seen = 1'b0; d_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);

            if (i_act && i_seen) begin
                i_act = ($urandom_range(0, 1) == 1);
                bus.i_addr = 16'($urandom);
            end else if (!i_act) begin
                i_act = ($urandom_range(0, 3) == 0);
                bus.i_addr = 16'($urandom);
            end else if ($urandom_range(0, 31) == 0) begin
                i_act = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) bus.i_addr = 16'($urandom);
            bus.i_rd = i_act;

            if (d_act && d_seen) begin
                d_act = ($urandom_range(0, 1) == 1);
                d_op  = $urandom_range(0, 1) == 1;
                bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
            end else if (!d_act) begin
                d_act = ($urandom_range(0, 2) == 0);
                d_op  = $urandom_range(0, 1) == 1;
                bus.d_addr = 16'($urandom); bus.d_wdata = 16'($urandom);
            end else if ($urandom_range(0, 31) == 0) begin
                d_act = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) bus.d_addr  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) bus.d_wdata = 16'($urandom);
            ill = ($urandom_range(0, 15) == 0);
            bus.d_rd = d_act & (~d_op | ill);
            bus.d_wr = d_act & (d_op | ill);

            bus.mem_done  = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = 16'($urandom);
            bus.mem_hit   = $urandom_range(0, 1) == 1;
            bus.mem_err   = ($urandom_range(0, 7) == 0);

            @(negedge clk);
            i_seen = bus.i_done;
            d_seen = bus.d_done;
            step();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
